sd_cmd_engine: RTL
==================

Name: sd_cmd_engine

Overview:
SD-card SPI-mode command sequencer that sits directly upstream of spi_front. Accepts one command request (index, argument, CRC7, response type) and drives spi_front through the full frame: a leading 0xFF pad, the 6-byte command, R1 polling and an optional 32-bit R3/R7 tail. It then releases CS with a trailing 0xFF and returns R1, the tail word and a timeout flag to the init/read controller above it.

Parameters:
NCR_MAX, 8, max 0xFF poll bytes sent after CRC before declaring timeout (1..255)

Ports:
spi_clk_in  in  1  clock, same net as spi_front's clock; all logic on posedge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
cmd_valid  in  1  request strobe; accepted when cmd_valid & cmd_ready
cmd_ready  out  1  high only in IDLE
cmd_index  in  6  command index (CMD0=0, CMD8=8, ...)
cmd_arg  in  32  command argument
cmd_crc  in  7  CRC7 of first 5 bytes, supplied by caller
cmd_resp_long  in  1  1 = R3/R7, read 32-bit tail after R1
resp_valid  out  1  one-cycle pulse, results valid
resp_r1  out  8  R1 byte; 0xFF on timeout
resp_data  out  32  R3/R7 tail; 0 if short or timeout
resp_timeout  out  1  no R1 within NCR_MAX polls
sd_cs_n  out  1  card chip select, active low
spi_begin  out  1  to spi_front
spi_wide  out  1  to spi_front; 1 = 32-bit transfer, 0 = 8-bit
data_mosi  out  32  to spi_front; 8-bit payload in [7:0], upper bits 0
data_miso  in  32  from spi_front; byte in [7:0], word in [31:0]
spi_busy  in  1  from spi_front

Behaviour:
- Reset (rst_n low at posedge): state IDLE, cmd_ready=1, sd_cs_n=1, spi_begin=0, spi_wide=0, data_mosi=0xFFFFFFFF, resp_valid=0, resp_r1=0xFF, resp_data=0, resp_timeout=0, poll counter=0. Reset mid-frame aborts immediately; no trailing byte is sent.
- Accept: in IDLE with cmd_valid=1, latch all cmd_* fields, clear resp_timeout and resp_data, and go to PRE. cmd_valid outside IDLE is ignored.
- Transfer handshake (every byte/word): set data_mosi and spi_wide, then raise spi_begin. Hold spi_begin until spi_busy is sampled 1, then drop it. Wait for spi_busy sampled 0, then data_miso is valid and is captured in that cycle. spi_begin is never high while spi_busy=1 past the first sampled-high cycle. data_mosi and spi_wide stay stable from spi_begin rise until spi_busy falls.
- States and transfers:
  - PRE: cs_n=1, byte 0xFF.
  - CMD: cs_n=0, byte {2'b01, cmd_index}.
  - ARG: wide, cmd_arg.
  - CRC: byte {cmd_crc, 1'b1}.
  - POLL: byte 0xFF, repeated. If captured byte[7]=0, latch resp_r1 and go to LONG (cmd_resp_long=1) or POST. Otherwise increment the counter; after NCR_MAX polls set resp_r1=0xFF and resp_timeout=1, then go to POST.
  - LONG: wide, 0xFFFFFFFF; latch resp_data.
  - POST: cs_n=1, byte 0xFF.
  - DONE: resp_valid=1 for one cycle, then IDLE.
- A success on the NCR_MAX-th poll counts as a response, not a timeout.
- sd_cs_n changes only between transfers, while spi_busy=0.
- Results hold until the next accept.

Decomposition:
- Shared package sd_pkg: state encoding, CMD start bits 2'b01, pad byte 0xFF, CRC end bit, common command indices (CMD0, CMD8, CMD17, CMD55, ACMD41, CMD58).
- One sub-module: spi_xfer_hs. It owns the begin/busy handshake (req in, done pulse out with captured data_miso) and is reused later by the data-block reader.

Test Plan:
- CMD0, arg 0, crc 0x4A, short; model returns 0x01 on poll 1 -> MOSI FF,40,00000000,95,FF,FF. resp_r1=0x01, resp_timeout=0, resp_data=0, one resp_valid pulse.
- CMD8, arg 0x000001AA, crc 0x43, long; R1 0x01 on poll 2, tail 0x000001AA -> MOSI bytes 48,000001AA,87. resp_r1=0x01, resp_data=0x000001AA.
- MISO held high, NCR_MAX=8 -> exactly 8 poll bytes. resp_r1=0xFF, resp_timeout=1, LONG skipped, POST sent, sd_cs_n=1 at resp_valid.
- R1 0x00 arrives on poll 8 (last) -> resp_timeout=0, resp_r1=0x00.
- rst_n low during ARG -> next cycle: sd_cs_n=1, spi_begin=0, cmd_ready=1. A new CMD0 afterwards completes normally.
- cmd_valid pulsed during POLL with different fields -> ignored; the in-flight result is unchanged and cmd_ready stays 0 until after DONE.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD SPI-mode definitions: sequencer and handshake state encodings,
// frame constants and common command indices.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_ARG,
    ST_CRC,
    ST_POLL,
    ST_LONG,
    ST_POST,
    ST_DONE
  } eng_state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_BEGIN,
    HS_WAIT
  } hs_state_t;

  localparam logic [1:0]  CMD_START = 2'b01;
  localparam logic [7:0]  PAD_BYTE  = 8'hFF;
  localparam logic [31:0] PAD_WORD  = 32'hFFFF_FFFF;
  localparam logic        CRC_END   = 1'b1;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/spi_xfer_hs.sv
// One spi_front transfer: latch payload, hold spi_begin until busy is seen,
// then capture data_miso when busy drops and pulse done.
module spi_xfer_hs
  import sd_pkg::*;
(
  input  logic        spi_clk_in,
  input  logic        rst_n,
  input  logic        req,
  input  logic        req_wide,
  input  logic [31:0] req_data,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        spi_begin,
  output logic        spi_wide,
  output logic [31:0] data_mosi,
  input  logic [31:0] data_miso,
  input  logic        spi_busy
);

  hs_state_t state_q, state_d;

  always_ff @(posedge spi_clk_in) begin
    if (!rst_n) begin
      state_q   <= HS_IDLE;
      spi_wide  <= 1'b0;
      data_mosi <= PAD_WORD;
      done      <= 1'b0;
      rx_data   <= 32'h0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      // payload is frozen here and only changes on the next request
      if (state_q == HS_IDLE && req) begin
        spi_wide  <= req_wide;
        data_mosi <= req_data;
      end
      if (state_q == HS_WAIT && !spi_busy) begin
        rx_data <= data_miso;
        done    <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HS_IDLE:  if (req)       state_d = HS_BEGIN;
      HS_BEGIN: if (spi_busy)  state_d = HS_WAIT;
      HS_WAIT:  if (!spi_busy) state_d = HS_IDLE;
      default:                 state_d = HS_IDLE;
    endcase
  end

  assign spi_begin = (state_q == HS_BEGIN);

endmodule

// File: rtl/sd_cmd_engine.sv
// SD SPI-mode command frame sequencer driving spi_front via spi_xfer_hs.
//   state | meaning
//   IDLE  | ready for a request        PRE  | cs high, 0xFF pad
//   CMD   | cs low, start+index byte   ARG  | 32-bit argument
//   CRC   | CRC7 + end bit             POLL | 0xFF until R1 or NCR_MAX polls
//   LONG  | 32-bit R3/R7 tail          POST | cs high, trailing 0xFF
//   DONE  | resp_valid pulse
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 8
) (
  input  logic        spi_clk_in,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        cmd_resp_long,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        sd_cs_n,
  output logic        spi_begin,
  output logic        spi_wide,
  output logic [31:0] data_mosi,
  input  logic [31:0] data_miso,
  input  logic        spi_busy
);

  localparam logic [7:0] POLL_LAST = 8'(NCR_MAX - 1);

  eng_state_t  state_q, state_d;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        long_q;
  logic [7:0]  poll_cnt;
  logic        in_flight;
  logic        xfer_active, xfer_req, xfer_wide, xfer_done;
  logic [31:0] xfer_data, xfer_rx;
  logic        poll_hit, poll_last;

  assign poll_hit    = ~xfer_rx[7];
  assign poll_last   = (poll_cnt == POLL_LAST);
  assign xfer_active = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign xfer_req    = xfer_active && !in_flight;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_DONE);

  spi_xfer_hs u_xfer (
    .spi_clk_in (spi_clk_in),
    .rst_n      (rst_n),
    .req        (xfer_req),
    .req_wide   (xfer_wide),
    .req_data   (xfer_data),
    .done       (xfer_done),
    .rx_data    (xfer_rx),
    .spi_begin  (spi_begin),
    .spi_wide   (spi_wide),
    .data_mosi  (data_mosi),
    .data_miso  (data_miso),
    .spi_busy   (spi_busy)
  );

  always_comb begin
    state_d   = state_q;
    xfer_wide = 1'b0;
    xfer_data = byte_word(PAD_BYTE);
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_PRE;
      ST_PRE:  if (xfer_done) state_d = ST_CMD;
      ST_CMD: begin
        xfer_data = byte_word({CMD_START, idx_q});
        if (xfer_done) state_d = ST_ARG;
      end
      ST_ARG: begin
        xfer_wide = 1'b1;
        xfer_data = arg_q;
        if (xfer_done) state_d = ST_CRC;
      end
      ST_CRC: begin
        xfer_data = byte_word({crc_q, CRC_END});
        if (xfer_done) state_d = ST_POLL;
      end
      ST_POLL: begin
        if (xfer_done) begin
          if (poll_hit)       state_d = long_q ? ST_LONG : ST_POST;
          else if (poll_last) state_d = ST_POST;
        end
      end
      ST_LONG: begin
        xfer_wide = 1'b1;
        xfer_data = PAD_WORD;
        if (xfer_done) state_d = ST_POST;
      end
      ST_POST: if (xfer_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_in) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sd_cs_n      <= 1'b1;
      resp_r1      <= PAD_BYTE;
      resp_data    <= 32'h0;
      resp_timeout <= 1'b0;
      poll_cnt     <= 8'h0;
      in_flight    <= 1'b0;
      idx_q        <= 6'h0;
      arg_q        <= 32'h0;
      crc_q        <= 7'h0;
      long_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer_req)       in_flight <= 1'b1;
      else if (xfer_done) in_flight <= 1'b0;

      if (state_q == ST_IDLE && cmd_valid) begin
        idx_q        <= cmd_index;
        arg_q        <= cmd_arg;
        crc_q        <= cmd_crc;
        long_q       <= cmd_resp_long;
        resp_timeout <= 1'b0;
        resp_data    <= 32'h0;
        poll_cnt     <= 8'h0;
      end

      if (xfer_done) begin
        case (state_q)
          ST_PRE: sd_cs_n <= 1'b0;
          ST_POLL: begin
            if (poll_hit) begin
              resp_r1 <= xfer_rx[7:0];
            end else if (poll_last) begin
              resp_r1      <= PAD_BYTE;
              resp_timeout <= 1'b1;
            end else begin
              poll_cnt <= poll_cnt + 8'd1;
            end
          end
          ST_LONG: resp_data <= xfer_rx;
          default: ;
        endcase
        // xfer_done only fires once busy is low, so cs moves between transfers
        if (state_d == ST_POST) sd_cs_n <= 1'b1;
      end
    end
  end

endmodule
